// File: rtl/rom_port_arbiter.sv
// Arbitrates the single ROM read port between instruction fetch (IF) and the load port (LD).
// Define ROM_ARB_RR_EN for round-robin on conflict; otherwise LD has fixed priority over IF.
module rom_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ROM_BYTES = 512,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_err,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {
    LAST_IF = 1'b0,
    LAST_LD = 1'b1
  } last_t;

  localparam logic [ADDR_W:0] ROM_LIM = (ADDR_W+1)'(ROM_BYTES);

  last_t             last_gnt;
  last_t             last_gnt_nxt;
  logic [ADDR_W-1:0] gnt_addr;
  logic [ADDR_W:0]   addr_end;
  logic              fault;
  logic [DATA_W-1:0] resp_data;

  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (if_req && ld_req) begin
`ifdef ROM_ARB_RR_EN
      if (last_gnt == LAST_LD) if_gnt = 1'b1;
      else                     ld_gnt = 1'b1;
`else
      ld_gnt = 1'b1;
`endif
    end else begin
      if_gnt = if_req;
      ld_gnt = ld_req;
    end

    gnt_addr = '0;
    if (ld_gnt)      gnt_addr = ld_addr;
    else if (if_gnt) gnt_addr = if_addr;

    // One extra bit on the end address keeps addresses near the top of the space from wrapping.
    addr_end  = {1'b0, gnt_addr} + (ADDR_W+1)'(3);
    fault     = (gnt_addr[1:0] != 2'b00) || (addr_end >= ROM_LIM);
    rom_en    = (if_gnt || ld_gnt) && !fault;
    rom_addr  = gnt_addr;
    resp_data = fault ? '0 : rom_data;

    last_gnt_nxt = last_gnt;
    if (if_gnt)      last_gnt_nxt = LAST_IF;
    else if (ld_gnt) last_gnt_nxt = LAST_LD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt  <= LAST_LD;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ld_rvalid <= 1'b0;
      ld_rdata  <= '0;
      ld_err    <= 1'b0;
    end else begin
      last_gnt  <= last_gnt_nxt;
      if_rvalid <= if_gnt;
      ld_rvalid <= ld_gnt;
      if (if_gnt) begin
        if_rdata <= resp_data;
        if_err   <= fault;
      end
      if (ld_gnt) begin
        ld_rdata <= resp_data;
        ld_err   <= fault;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (if_req && ld_req && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter; ROM byte at address a reads as a[7:0]+0x11.
module tb_rom_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, ld_req;
  logic [ADDR_W-1:0] if_addr, ld_addr;
  logic              if_gnt, ld_gnt, if_rvalid, ld_rvalid, if_err, ld_err;
  logic [DATA_W-1:0] if_rdata, ld_rdata, rom_data;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [CNT_W-1:0]  conflict_cnt;
  logic [7:0]        b0;

  int checks   = 0;
  int failures = 0;

  rom_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_BYTES(512), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Disabled reads return a poison word so a leaked fault response is visible.
  always_comb begin
    b0 = rom_addr[7:0] + 8'h11;
    if (rom_en) rom_data = {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
    else        rom_data = 32'hDEAD_BEEF;
  end

  task automatic do_reset();
    if_req = 1'b0; ld_req = 1'b0; if_addr = '0; ld_addr = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b0; ld_req = 1'b0; if_addr = '0; ld_addr = '0;
    #1;
    checks++; if (if_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid if=%b ld=%b want 0 0", if_rvalid, ld_rvalid); end
    checks++; if (if_rdata !== '0 || ld_rdata !== '0) begin failures++; $display("FAIL reset_rdata if=%h ld=%h want 0 0", if_rdata, ld_rdata); end
    checks++; if (if_err !== 1'b0 || ld_err !== 1'b0) begin failures++; $display("FAIL reset_err if=%b ld=%b want 0 0", if_err, ld_err); end
    checks++; if (conflict_cnt !== '0) begin failures++; $display("FAIL reset_cnt got %0d want 0", conflict_cnt); end
    checks++; if (rom_en !== 1'b0 || rom_addr !== '0) begin failures++; $display("FAIL reset_idle rom_en=%b rom_addr=%h want 0 0", rom_en, rom_addr); end
    if_req = 1'b1; #1;
    checks++; if (if_gnt !== 1'b1 || ld_gnt !== 1'b0 || rom_en !== 1'b1) begin failures++; $display("FAIL reset_comb_if gnt=%b%b en=%b want 10 1", if_gnt, ld_gnt, rom_en); end
    if_req = 1'b0; ld_req = 1'b1; #1;
    checks++; if (ld_gnt !== 1'b1 || if_gnt !== 1'b0) begin failures++; $display("FAIL reset_comb_ld gnt=%b%b want 01", if_gnt, ld_gnt); end
    ld_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (if_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin failures++; $display("FAIL reset_hold_rvalid if=%b ld=%b want 0 0", if_rvalid, ld_rvalid); end
  endtask

  task automatic test_fetch();
    do_reset();
    if_req = 1'b1; if_addr = 32'h0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (if_gnt !== 1'b1 || rom_addr !== 32'h0) begin failures++; $display("FAIL fetch_gnt c%0d gnt=%b addr=%h want 1 0", i, if_gnt, rom_addr); end
      @(posedge clk); #1;
      checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1112_1314 || if_err !== 1'b0) begin failures++; $display("FAIL fetch_resp c%0d v=%b d=%h e=%b want 1 11121314 0", i, if_rvalid, if_rdata, if_err); end
      checks++; if (ld_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_ld_quiet c%0d got %b want 0", i, ld_rvalid); end
    end
    if_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h1112_1314) begin failures++; $display("FAIL fetch_drop v=%b d=%h want 0 11121314", if_rvalid, if_rdata); end
    checks++; if (conflict_cnt !== 4'd0) begin failures++; $display("FAIL fetch_cnt got %0d want 0", conflict_cnt); end
  endtask

  task automatic test_conflict();
    logic exp_if;
    do_reset();
    if_req = 1'b1; if_addr = 32'h10; ld_req = 1'b1; ld_addr = 32'h20;
    for (int unsigned i = 0; i < 4; i++) begin
`ifdef ROM_ARB_RR_EN
      exp_if = (i % 2 == 0);
`else
      exp_if = 1'b0;
`endif
      @(negedge clk);
      checks++; if (if_gnt !== exp_if || ld_gnt !== !exp_if) begin failures++; $display("FAIL conflict_gnt c%0d got if=%b ld=%b want if=%b ld=%b", i, if_gnt, ld_gnt, exp_if, !exp_if); end
      checks++; if (rom_addr !== (exp_if ? 32'h10 : 32'h20)) begin failures++; $display("FAIL conflict_addr c%0d got %h", i, rom_addr); end
      @(posedge clk); #1;
      if (exp_if) begin
        checks++; if (if_rvalid !== 1'b1 || ld_rvalid !== 1'b0 || if_rdata !== 32'h2122_2324) begin failures++; $display("FAIL conflict_resp_if c%0d v=%b%b d=%h want 10 21222324", i, if_rvalid, ld_rvalid, if_rdata); end
      end else begin
        checks++; if (ld_rvalid !== 1'b1 || if_rvalid !== 1'b0 || ld_rdata !== 32'h3132_3334) begin failures++; $display("FAIL conflict_resp_ld c%0d v=%b%b d=%h want 01 31323334", i, if_rvalid, ld_rvalid, ld_rdata); end
      end
    end
    if_req = 1'b0; ld_req = 1'b0;
    checks++; if (conflict_cnt !== 4'd4) begin failures++; $display("FAIL conflict_cnt got %0d want 4", conflict_cnt); end
  endtask

  task automatic test_misaligned();
    do_reset();
    ld_req = 1'b1; ld_addr = 32'h6;
    @(negedge clk);
    checks++; if (ld_gnt !== 1'b1 || rom_en !== 1'b0) begin failures++; $display("FAIL misalign_gnt gnt=%b en=%b want 1 0", ld_gnt, rom_en); end
    @(posedge clk); #1;
    ld_req = 1'b0;
    checks++; if (ld_rvalid !== 1'b1 || ld_err !== 1'b1 || ld_rdata !== '0) begin failures++; $display("FAIL misalign_resp v=%b e=%b d=%h want 1 1 0", ld_rvalid, ld_err, ld_rdata); end
  endtask

  task automatic test_bounds();
    logic [ADDR_W-1:0] addrs [3] = '{32'h1FD, 32'hFFFF_FFFC, 32'h1FC};
    logic              errs  [3] = '{1'b1, 1'b1, 1'b0};
    logic [DATA_W-1:0] datas [3] = '{32'h0, 32'h0, 32'h0D0E_0F10};
    do_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = addrs[i];
      @(negedge clk);
      checks++; if (if_gnt !== 1'b1 || rom_en !== !errs[i]) begin failures++; $display("FAIL bounds_en a=%h gnt=%b en=%b want 1 %b", addrs[i], if_gnt, rom_en, !errs[i]); end
      @(posedge clk); #1;
      checks++; if (if_rvalid !== 1'b1 || if_err !== errs[i] || if_rdata !== datas[i]) begin failures++; $display("FAIL bounds_resp a=%h v=%b e=%b d=%h want 1 %b %h", addrs[i], if_rvalid, if_err, if_rdata, errs[i], datas[i]); end
    end
    if_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] datas [3] = '{32'h1112_1314, 32'h1516_1718, 32'h191A_1B1C};
    do_reset();
    ld_req = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      ld_addr = ADDR_W'(4 * i);
      @(posedge clk); #1;
      checks++; if (ld_rvalid !== 1'b1 || ld_rdata !== datas[i] || ld_err !== 1'b0) begin failures++; $display("FAIL b2b c%0d v=%b d=%h e=%b want 1 %h 0", i, ld_rvalid, ld_rdata, ld_err, datas[i]); end
    end
    ld_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_req = 1'b1; ld_req = 1'b1; if_addr = 32'h0; ld_addr = 32'h20;
    @(posedge clk); #1;
    ld_req = 1'b0;
    @(negedge clk);
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL rstmid_gnt got %b want 1", if_gnt); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (if_rvalid !== 1'b0 || conflict_cnt !== 4'd0) begin failures++; $display("FAIL rstmid_discard v=%b cnt=%0d want 0 0", if_rvalid, conflict_cnt); end
    if_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    checks++; if (if_gnt !== 1'b1 || rom_en !== 1'b1) begin failures++; $display("FAIL rstmid_regnt gnt=%b en=%b want 1 1", if_gnt, rom_en); end
    @(posedge clk); #1;
    if_req = 1'b0;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h2122_2324) begin failures++; $display("FAIL rstmid_resp v=%b d=%h want 1 21222324", if_rvalid, if_rdata); end
  endtask

  task automatic test_saturate();
    do_reset();
    if_req = 1'b1; ld_req = 1'b1; if_addr = 32'h10; ld_addr = 32'h20;
    repeat (14) @(posedge clk);
    #1;
    checks++; if (conflict_cnt !== 4'd14) begin failures++; $display("FAIL sat_mid got %0d want 14", conflict_cnt); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (conflict_cnt !== 4'd15) begin failures++; $display("FAIL sat_top got %0d want 15", conflict_cnt); end
    if_req = 1'b0; ld_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_conflict();
    test_misaligned();
    test_bounds();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
